// File: rtl/adc_capture_buffer.sv
// ADC capture: arm then trigger edge stores len beats in RAM, then replays them as AXIS with tlast.
// Readout latency 2 cycles from READOUT&chan_sel, 1 beat/cycle; a 2-entry skid absorbs tready stalls, ADC never stalled.
module adc_capture_buffer #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10
) (
    input  logic              pl_clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              trigger,
    input  logic              abort,
    input  logic              chan_sel,
    input  logic [ADDR_W:0]   cap_len,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, CAPTURE = 3'd2, READOUT = 3'd3} state_t;

    state_t            state_q, state_d;
    logic              arm_q, trig_q;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, out_cnt_q, out_cnt_d;
    logic              rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0] ram_rd_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] skid_q [2];
    logic              skid_head_q, skid_head_d;
    logic [1:0]        skid_cnt_q, skid_cnt_d;
    logic              hold_q, hold_d;
    logic              arm_edge, trig_edge, wr_en, rd_en, pop, clear;
    logic [2:0]        skid_room;

    always_comb begin
        arm_edge      = arm & ~arm_q;
        trig_edge     = trigger & ~trig_q;
        s_axis_tready = 1'b1;
        busy          = (state_q != IDLE);
        state         = state_q;
        // Once presented, a beat stays valid until taken even if chan_sel drops.
        m_axis_tvalid = (skid_cnt_q != 2'd0) && (chan_sel || hold_q);
        m_axis_tdata  = skid_q[skid_head_q];
        m_axis_tlast  = m_axis_tvalid && (out_cnt_q == len_q - ONE);
        pop           = m_axis_tvalid && m_axis_tready;
        done          = pop && m_axis_tlast && !abort;
        wr_en         = (state_q == CAPTURE) && s_axis_tvalid && !abort;
        // Occupancy the skid will hold after this edge, counting the read in flight.
        skid_room     = {1'b0, skid_cnt_q} + {2'b00, rd_vld_q} - {2'b00, pop};
        rd_en         = (state_q == READOUT) && chan_sel && !abort &&
                        (rd_ptr_q < len_q) && (skid_room < 3'd2);

        state_d     = state_q;
        len_d       = len_q;
        clear       = 1'b0;
        wr_ptr_d    = wr_en ? wr_ptr_q + ONE : wr_ptr_q;
        rd_ptr_d    = rd_en ? rd_ptr_q + ONE : rd_ptr_q;
        out_cnt_d   = pop ? out_cnt_q + ONE : out_cnt_q;
        rd_vld_d    = rd_en;
        skid_cnt_d  = skid_cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
        skid_head_d = skid_head_q ^ pop;
        hold_d      = m_axis_tvalid && !m_axis_tready;

        case (state_q)
            IDLE: if (arm_edge) begin
                state_d = ARMED;
                len_d   = (cap_len == '0 || cap_len > FULL) ? FULL : cap_len;
                clear   = 1'b1;
            end
            ARMED:   if (trig_edge) state_d = CAPTURE;
            CAPTURE: if (wr_en && (wr_ptr_q + ONE == len_q)) state_d = READOUT;
            READOUT: if (done) begin
                state_d = IDLE;
                clear   = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            clear   = 1'b1;
        end
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_cnt_d   = '0;
            rd_vld_d    = 1'b0;
            skid_cnt_d  = 2'd0;
            skid_head_d = 1'b0;
            hold_d      = 1'b0;
        end
    end

    always_ff @(posedge pl_clk) begin
        if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= s_axis_tdata;
        if (rd_en) ram_rd_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
    end

    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            arm_q       <= 1'b0;
            trig_q      <= 1'b0;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_cnt_q   <= '0;
            rd_vld_q    <= 1'b0;
            skid_q[0]   <= '0;
            skid_q[1]   <= '0;
            skid_head_q <= 1'b0;
            skid_cnt_q  <= 2'd0;
            hold_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm;
            trig_q      <= trigger;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_cnt_q   <= out_cnt_d;
            rd_vld_q    <= rd_vld_d;
            skid_head_q <= skid_head_d;
            skid_cnt_q  <= skid_cnt_d;
            hold_q      <= hold_d;
            if (rd_vld_q && !clear) skid_q[skid_head_q ^ skid_cnt_q[0]] <= ram_rd_q;
        end
    end
endmodule
